// File: rtl/mii_frame_monitor.sv
// Passive MII TX-path monitor: measures frame and inter-packet-gap lengths,
// flags protocol violations and keeps saturating frame/error statistics.
module mii_frame_monitor #(
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned CTRL_WIDTH  = DATA_WIDTH / 8,
   parameter logic [7:0]  IDLE_CODE   = 8'h07,
   parameter logic [7:0]  START_CODE  = 8'hFB,
   parameter logic [7:0]  TERM_CODE   = 8'hFD,
   parameter int unsigned MIN_PAYLOAD = 46,
   parameter int unsigned MAX_PAYLOAD = 1500,
   parameter int unsigned MIN_IPG     = 12,
   parameter int unsigned MAX_IPG     = 40,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic [CTRL_WIDTH-1:0] i_tx_ctrl,
   input  logic                  i_clear_counters,
   output logic                  o_in_frame,
   output logic                  o_frame_done,
   output logic [15:0]           o_frame_len,
   output logic                  o_payload_error,
   output logic                  o_gap_done,
   output logic [15:0]           o_ipg_len,
   output logic                  o_intergap_error,
   output logic                  o_other_error,
   output logic [CNT_WIDTH-1:0]  o_frame_count,
   output logic [CNT_WIDTH-1:0]  o_error_count
);

   localparam int unsigned      LEN_W    = 16;
   localparam logic [LEN_W-1:0] LANES    = LEN_W'(CTRL_WIDTH);
   localparam logic [LEN_W-1:0] LANES_M1 = LEN_W'(CTRL_WIDTH - 1);

   typedef enum logic [1:0] {
      WAIT_START = 2'd0,
      IN_FRAME   = 2'd1,
      IN_GAP     = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [LEN_W-1:0]       len_q, len_d;
   logic [LEN_W-1:0]       gap_q, gap_d;
   logic                   err_q, err_d;

   logic [CTRL_WIDTH-1:0]  lane_idle;
   logic [CTRL_WIDTH-1:0]  lane_term;
   logic                   start_lane0;
   logic                   term_hit;
   logic [LEN_W-1:0]       term_lane;
   logic                   frame_word_err;
   logic                   gap_word_err;

   logic                   in_frame_d;
   logic                   frame_done_d;
   logic [LEN_W-1:0]       frame_len_d;
   logic                   payload_err_d;
   logic                   gap_done_d;
   logic [LEN_W-1:0]       ipg_len_d;
   logic                   intergap_err_d;
   logic                   other_err_d;
   logic                   report_err;
   logic [CNT_WIDTH-1:0]   frame_cnt_d;
   logic [CNT_WIDTH-1:0]   error_cnt_d;

   function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a,
                                                input logic [LEN_W-1:0] b);
      logic [LEN_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[LEN_W] ? {LEN_W{1'b1}} : sum[LEN_W-1:0];
   endfunction

   function automatic logic out_of_range(input logic [LEN_W-1:0] v,
                                         input int unsigned      lo,
                                         input int unsigned      hi);
      return (32'(v) < lo) || (32'(v) > hi);
   endfunction

   // Per-lane classification of the incoming word.
   always_comb begin
      lane_idle = '0;
      lane_term = '0;
      for (int unsigned k = 0; k < CTRL_WIDTH; k++) begin
         lane_idle[k] = i_tx_ctrl[k] && (i_tx_data[8*k +: 8] == IDLE_CODE);
         lane_term[k] = i_tx_ctrl[k] && (i_tx_data[8*k +: 8] == TERM_CODE);
      end
   end

   // First TERM lane wins; lanes above it must be idle, control below it is illegal.
   always_comb begin
      start_lane0    = i_tx_ctrl[0] && (i_tx_data[7:0] == START_CODE);
      term_hit       = 1'b0;
      term_lane      = '0;
      frame_word_err = 1'b0;
      gap_word_err   = ~(&lane_idle);
      for (int unsigned k = 0; k < CTRL_WIDTH; k++) begin
         if (term_hit) begin
            if (!lane_idle[k]) begin
               frame_word_err = 1'b1;
            end
         end else if (lane_term[k]) begin
            term_hit  = 1'b1;
            term_lane = LEN_W'(k);
         end else if (i_tx_ctrl[k]) begin
            frame_word_err = 1'b1;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      gap_d          = gap_q;
      err_d          = err_q;
      frame_done_d   = 1'b0;
      gap_done_d     = 1'b0;
      frame_len_d    = o_frame_len;
      payload_err_d  = o_payload_error;
      ipg_len_d      = o_ipg_len;
      intergap_err_d = o_intergap_error;
      other_err_d    = o_other_error;

      if (i_valid) begin
         case (state_q)
            WAIT_START: begin
               if (start_lane0) begin
                  state_d = IN_FRAME;
                  len_d   = LANES_M1;
                  err_d   = 1'b0;
               end
            end
            IN_FRAME: begin
               if (start_lane0) begin
                  // Restart without TERM: close the truncated frame as an error.
                  frame_done_d  = 1'b1;
                  frame_len_d   = len_q;
                  payload_err_d = out_of_range(len_q, MIN_PAYLOAD, MAX_PAYLOAD);
                  other_err_d   = 1'b1;
                  len_d         = LANES_M1;
                  err_d         = 1'b0;
               end else if (term_hit) begin
                  frame_done_d  = 1'b1;
                  frame_len_d   = sat_add(len_q, term_lane);
                  payload_err_d = out_of_range(frame_len_d, MIN_PAYLOAD, MAX_PAYLOAD);
                  other_err_d   = err_q || frame_word_err;
                  state_d       = IN_GAP;
                  gap_d         = LANES_M1 - term_lane;
                  err_d         = 1'b0;
               end else begin
                  len_d = sat_add(len_q, LANES);
                  err_d = err_q || frame_word_err;
               end
            end
            IN_GAP: begin
               if (start_lane0) begin
                  gap_done_d     = 1'b1;
                  ipg_len_d      = gap_q;
                  intergap_err_d = out_of_range(gap_q, MIN_IPG, MAX_IPG);
                  other_err_d    = err_q;
                  state_d        = IN_FRAME;
                  len_d          = LANES_M1;
                  err_d          = 1'b0;
               end else begin
                  gap_d = sat_add(gap_q, LANES);
                  err_d = err_q || gap_word_err;
               end
            end
            default: begin
               state_d = WAIT_START;
            end
         endcase
      end

      in_frame_d = (state_d == IN_FRAME);

      report_err = (frame_done_d && (payload_err_d || other_err_d)) ||
                   (gap_done_d && (intergap_err_d || other_err_d));

      // Clear has priority over a same-cycle increment.
      frame_cnt_d = o_frame_count;
      error_cnt_d = o_error_count;
      if (i_clear_counters) begin
         frame_cnt_d = '0;
         error_cnt_d = '0;
      end else begin
         if (frame_done_d && (o_frame_count != {CNT_WIDTH{1'b1}})) begin
            frame_cnt_d = o_frame_count + CNT_WIDTH'(1);
         end
         if (report_err && (o_error_count != {CNT_WIDTH{1'b1}})) begin
            error_cnt_d = o_error_count + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q          <= WAIT_START;
         len_q            <= '0;
         gap_q            <= '0;
         err_q            <= 1'b0;
         o_in_frame       <= 1'b0;
         o_frame_done     <= 1'b0;
         o_frame_len      <= '0;
         o_payload_error  <= 1'b0;
         o_gap_done       <= 1'b0;
         o_ipg_len        <= '0;
         o_intergap_error <= 1'b0;
         o_other_error    <= 1'b0;
         o_frame_count    <= '0;
         o_error_count    <= '0;
      end else begin
         state_q          <= state_d;
         len_q            <= len_d;
         gap_q            <= gap_d;
         err_q            <= err_d;
         o_in_frame       <= in_frame_d;
         o_frame_done     <= frame_done_d;
         o_frame_len      <= frame_len_d;
         o_payload_error  <= payload_err_d;
         o_gap_done       <= gap_done_d;
         o_ipg_len        <= ipg_len_d;
         o_intergap_error <= intergap_err_d;
         o_other_error    <= other_err_d;
         o_frame_count    <= frame_cnt_d;
         o_error_count    <= error_cnt_d;
      end
   end

endmodule

// File: tb/tb_mii_frame_monitor.sv
// Directed bench for mii_frame_monitor: 64-bit and 32-bit instances, expected
// frame/gap reports queued as words are driven and popped on each done pulse.
module tb_mii_frame_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst64, v64, clr64;
   logic [63:0] d64;
   logic [7:0]  c64;
   logic        inf64, fd64, pe64, gd64, ie64, oe64;
   logic [15:0] fl64, il64;
   logic [31:0] fc64, ec64;

   logic        rst32, v32, clr32;
   logic [31:0] d32;
   logic [3:0]  c32;
   logic        inf32, fd32, pe32, gd32, ie32, oe32;
   logic [15:0] fl32, il32;
   logic [31:0] fc32, ec32;

   mii_frame_monitor #(.DATA_WIDTH(64)) dut64 (
      .clk(clk), .i_rst(rst64), .i_valid(v64), .i_tx_data(d64), .i_tx_ctrl(c64),
      .i_clear_counters(clr64), .o_in_frame(inf64), .o_frame_done(fd64),
      .o_frame_len(fl64), .o_payload_error(pe64), .o_gap_done(gd64), .o_ipg_len(il64),
      .o_intergap_error(ie64), .o_other_error(oe64), .o_frame_count(fc64),
      .o_error_count(ec64)
   );

   mii_frame_monitor #(.DATA_WIDTH(32)) dut32 (
      .clk(clk), .i_rst(rst32), .i_valid(v32), .i_tx_data(d32), .i_tx_ctrl(c32),
      .i_clear_counters(clr32), .o_in_frame(inf32), .o_frame_done(fd32),
      .o_frame_len(fl32), .o_payload_error(pe32), .o_gap_done(gd32), .o_ipg_len(il32),
      .o_intergap_error(ie32), .o_other_error(oe32), .o_frame_count(fc32),
      .o_error_count(ec32)
   );

   typedef struct {
      bit          gap;
      int unsigned len;
      bit          len_err;
      bit          other;
      int unsigned fc;
      int unsigned ec;
   } rep_t;

   rep_t q64[$];
   rep_t q32[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state for the 64-bit stream.
   int unsigned m_fc = 0, m_ec = 0, m_gap = 0;
   int unsigned m32_fc = 0, m32_ec = 0;
   bit          m_in_gap = 1'b0, m_gap_other = 1'b0, m_toggle = 1'b0;

   logic [63:0] wd;
   logic [7:0]  wc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void push_frame(input bit w32, input int unsigned len,
                                      input bit other, input bit clr);
      rep_t r;
      r.gap     = 1'b0;
      r.len     = len;
      r.len_err = (len < 46) || (len > 1500);
      r.other   = other;
      if (w32) begin
         m32_fc++;
         if (r.len_err || other) m32_ec++;
         if (clr) begin m32_fc = 0; m32_ec = 0; end
         r.fc = m32_fc; r.ec = m32_ec;
         q32.push_back(r);
      end else begin
         m_fc++;
         if (r.len_err || other) m_ec++;
         if (clr) begin m_fc = 0; m_ec = 0; end
         r.fc = m_fc; r.ec = m_ec;
         q64.push_back(r);
      end
   endfunction

   function automatic void push_gap(input int unsigned len, input bit other);
      rep_t r;
      r.gap     = 1'b1;
      r.len     = len;
      r.len_err = (len < 12) || (len > 40);
      r.other   = other;
      if (r.len_err || other) m_ec++;
      r.fc = m_fc; r.ec = m_ec;
      q64.push_back(r);
   endfunction

   function automatic void mk_term(input int nl, input int t,
                                   output logic [63:0] d, output logic [7:0] c);
      d = {$urandom, $urandom};
      c = '0;
      for (int k = 0; k < nl; k++) begin
         if (k == t) begin
            d[8*k +: 8] = 8'hFD; c[k] = 1'b1;
         end else if (k > t) begin
            d[8*k +: 8] = 8'h07; c[k] = 1'b1;
         end
      end
   endfunction

   task automatic drive64(input logic [63:0] d, input logic [7:0] c);
      if (m_toggle) begin
         @(negedge clk);
         d64 = 64'hFB; c64 = 8'h01; v64 = 1'b0; clr64 = 1'b0;
      end
      @(negedge clk);
      d64 = d; c64 = c; v64 = 1'b1; clr64 = 1'b0;
   endtask

   task automatic drive32(input logic [31:0] d, input logic [3:0] c);
      @(negedge clk);
      d32 = d; c32 = c; v32 = 1'b1; clr32 = 1'b0;
   endtask

   task automatic send_start64();
      logic [63:0] d;
      d = {$urandom, $urandom};
      d[7:0] = 8'hFB;
      if (m_in_gap) push_gap(m_gap, m_gap_other);
      m_in_gap = 1'b0; m_gap_other = 1'b0;
      drive64(d, 8'h01);
   endtask

   task automatic send_data64(input int n);
      repeat (n) drive64({$urandom, $urandom}, 8'h00);
   endtask

   task automatic send_term64(input int t, input int unsigned len, input bit other, input bit clr);
      logic [63:0] d;
      logic [7:0]  c;
      mk_term(8, t, d, c);
      push_frame(1'b0, len, other, clr);
      drive64(d, c);
      clr64 = clr;
      m_in_gap = 1'b1; m_gap = 7 - t; m_gap_other = 1'b0;
   endtask

   task automatic send_idle64();
      drive64({8{8'h07}}, 8'hFF);
      m_gap += 8;
   endtask

   task automatic check_zero64(input string p);
      chk({p, "_in_frame"}, inf64, 1'b0);
      chk({p, "_frame_done"}, fd64, 1'b0);
      chk({p, "_frame_len"}, fl64, 16'd0);
      chk({p, "_payload_err"}, pe64, 1'b0);
      chk({p, "_gap_done"}, gd64, 1'b0);
      chk({p, "_ipg_len"}, il64, 16'd0);
      chk({p, "_intergap_err"}, ie64, 1'b0);
      chk({p, "_other_err"}, oe64, 1'b0);
      chk({p, "_frame_count"}, fc64, 32'd0);
      chk({p, "_error_count"}, ec64, 32'd0);
   endtask

   // Scoreboard: every done pulse must match the oldest queued report.
   always @(negedge clk) begin
      rep_t r;
      if (fd64 || gd64) begin
         chk("rep64_pending", q64.size() != 0, 1'b1);
         if (q64.size() != 0) begin
            r = q64.pop_front();
            chk("rep64_frame_done", fd64, !r.gap);
            chk("rep64_gap_done", gd64, r.gap);
            chk("rep64_len", r.gap ? il64 : fl64, r.len);
            chk("rep64_len_err", r.gap ? ie64 : pe64, r.len_err);
            chk("rep64_other_err", oe64, r.other);
            chk("rep64_frame_count", fc64, r.fc);
            chk("rep64_error_count", ec64, r.ec);
         end
      end
      if (fd32 || gd32) begin
         chk("rep32_pending", q32.size() != 0, 1'b1);
         if (q32.size() != 0) begin
            r = q32.pop_front();
            chk("rep32_frame_done", fd32, !r.gap);
            chk("rep32_gap_done", gd32, r.gap);
            chk("rep32_len", r.gap ? il32 : fl32, r.len);
            chk("rep32_len_err", r.gap ? ie32 : pe32, r.len_err);
            chk("rep32_other_err", oe32, r.other);
            chk("rep32_frame_count", fc32, r.fc);
            chk("rep32_error_count", ec32, r.ec);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst64 = 1'b1; v64 = 1'b0; clr64 = 1'b0; d64 = '0; c64 = '0;
      rst32 = 1'b1; v32 = 1'b0; clr32 = 1'b0; d32 = '0; c32 = '0;
      repeat (3) @(negedge clk);
      check_zero64("reset");
      chk("reset32_frame_count", fc32, 32'd0);
      rst64 = 1'b0; rst32 = 1'b0;

      // 66-byte frame, then one idle word giving a 12-byte gap.
      send_start64();
      send_data64(1);
      chk("t1_in_frame", inf64, 1'b1);
      send_data64(6);
      send_term64(3, 66, 1'b0, 1'b0);
      send_idle64();
      chk("t1_in_gap", inf64, 1'b0);
      @(negedge clk); v64 = 1'b0;
      repeat (2) @(negedge clk);

      // Short frame (20 bytes) -> payload error; gap 12 on its START.
      send_start64();
      send_data64(1);
      send_term64(5, 20, 1'b0, 1'b0);
      send_idle64();

      // Gap of 10 (error), then 66-byte frame followed directly by START: gap 4.
      send_start64();
      send_data64(7);
      send_term64(3, 66, 1'b0, 1'b0);

      // Non-idle data lane after TERM -> other error.
      send_start64();
      send_data64(6);
      mk_term(8, 2, wd, wc);
      wd[47:40] = 8'hAA; wc[5] = 1'b0;
      push_frame(1'b0, 57, 1'b1, 1'b0);
      drive64(wd, wc);
      m_in_gap = 1'b1; m_gap = 5; m_gap_other = 1'b0;
      send_idle64();

      // 8'hFE control inside the frame; length still counted.
      send_start64();
      send_data64(1);
      wd = {$urandom, $urandom};
      wd[39:32] = 8'hFE;
      drive64(wd, 8'h10);
      send_data64(5);
      send_term64(3, 66, 1'b1, 1'b0);
      send_idle64();
      drive64({$urandom, $urandom}, 8'h00);
      m_gap += 8; m_gap_other = 1'b1;

      // START after 3 data words closes a 31-byte frame; new frame tracked normally.
      send_start64();
      send_data64(3);
      push_frame(1'b0, 31, 1'b1, 1'b0);
      send_start64();
      send_data64(7);
      send_term64(3, 66, 1'b0, 1'b0);
      send_idle64();

      // i_valid low every other cycle, with a START word presented while invalid.
      m_toggle = 1'b1;
      send_start64();
      send_data64(7);
      send_term64(3, 66, 1'b0, 1'b0);
      send_idle64();
      m_toggle = 1'b0;

      // Counter clear coincident with a frame completion.
      send_start64();
      send_data64(7);
      send_term64(3, 66, 1'b0, 1'b1);
      send_idle64();

      // Reset mid-frame: no report, everything back to zero.
      send_start64();
      send_data64(3);
      @(negedge clk);
      rst64 = 1'b1; d64 = {$urandom, $urandom}; c64 = 8'h00; v64 = 1'b1;
      @(negedge clk);
      check_zero64("midrst");
      m_in_gap = 1'b0; m_fc = 0; m_ec = 0;
      rst64 = 1'b0; v64 = 1'b0;

      // After reset: TERM is ignored while waiting, and the first frame has no gap report.
      mk_term(8, 3, wd, wc);
      drive64(wd, wc);
      send_data64(1);
      send_start64();
      send_data64(7);
      send_term64(3, 66, 1'b0, 1'b0);
      @(negedge clk); v64 = 1'b0;

      // 32-bit instance: START, 15 data words, TERM in lane 1 -> 64 bytes.
      wd = {$urandom, $urandom};
      wd[7:0] = 8'hFB;
      drive32(wd[31:0], 4'h1);
      drive32($urandom, 4'h0);
      chk("w32_in_frame", inf32, 1'b1);
      repeat (14) drive32($urandom, 4'h0);
      mk_term(4, 1, wd, wc);
      push_frame(1'b1, 64, 1'b0, 1'b0);
      drive32(wd[31:0], wc[3:0]);
      @(negedge clk); v32 = 1'b0;

      repeat (4) @(negedge clk);
      chk("q64_drained", q64.size(), 0);
      chk("q32_drained", q32.size(), 0);
      chk("final_frame_count64", fc64, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
